// File: rtl/lu_pkg.sv
// Shared types and constants for the logical-unit arbiter: FSM states and function codes.
package lu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } luState_e;

    localparam logic [1:0] LU_AND     = 2'b00;
    localparam logic [1:0] LU_OR      = 2'b01;
    localparam logic [1:0] LU_XOR     = 2'b10;
    localparam logic [1:0] LU_NOR_LUI = 2'b11;

endpackage

// File: rtl/logical_unit.sv
// Combinational bitwise unit: AND/OR/XOR/NOR, or load-upper-immediate of b when i is set.
module logical_unit
    import lu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   af,
    input  logic         i,
    output logic [N-1:0] res
);

    always_comb begin
        res = '0;
        case (af)
            LU_AND:  res = a & b;
            LU_OR:   res = a | b;
            LU_XOR:  res = a ^ b;
            default: res = i ? {b[N/2-1:0], {(N/2){1'b0}}} : ~(a | b);
        endcase
    end

endmodule

// File: rtl/lu_rr_pick.sv
// Round-robin picker: lowest valid index at or above ptr, wrapping modulo P.
module lu_rr_pick #(
    parameter int P = 4,
    parameter int W = (P > 1) ? $clog2(P) : 1
) (
    input  logic [P-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        any = |valid;
        idx = '0;
        for (int off = P - 1; off >= 0; off--) begin
            if (valid[(int'(ptr) + off) % P]) begin
                idx = W'((int'(ptr) + off) % P);
            end
        end
    end

endmodule

// File: rtl/lu_arbiter.sv
// Shares one logical_unit among P requesters with round-robin arbitration (IDLE/EXEC/RESP).
module lu_arbiter
    import lu_pkg::*;
#(
    parameter int N = 32,
    parameter int P = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P-1:0]   req_valid,
    output logic [P-1:0]   req_ready,
    input  logic [P*N-1:0] req_a,
    input  logic [P*N-1:0] req_b,
    input  logic [P*2-1:0] req_af,
    input  logic [P-1:0]   req_i,
    output logic [P-1:0]   rsp_valid,
    input  logic [P-1:0]   rsp_ready,
    output logic [N-1:0]   rsp_res
);

    localparam int W = (P > 1) ? $clog2(P) : 1;

    luState_e       state_q;
    logic [W-1:0]   rrPtr_q;
    logic [W-1:0]   rrPtr_d;
    logic [W-1:0]   gnt_q;
    logic [N-1:0]   res_q;
    logic [N-1:0]   opA_q;
    logic [N-1:0]   opB_q;
    logic [1:0]     opAf_q;
    logic           opImm_q;
    logic [P-1:0]   rspValid_q;
    logic [P-1:0]   gntOneHot;

    logic           pickAny;
    logic [W-1:0]   pickIdx;
    logic           canAccept;
    logic [N-1:0]   luRes;

    lu_rr_pick #(
        .P (P),
        .W (W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rrPtr_q),
        .any   (pickAny),
        .idx   (pickIdx)
    );

    logical_unit #(
        .N (N)
    ) u_lu (
        .a   (opA_q),
        .b   (opB_q),
        .af  (opAf_q),
        .i   (opImm_q),
        .res (luRes)
    );

    // A new request can be taken when idle, or when the pending response retires this cycle.
    always_comb begin
        canAccept = rst_n && pickAny &&
                    ((state_q == IDLE) || ((state_q == RESP) && rsp_ready[gnt_q]));
        req_ready = '0;
        if (canAccept) begin
            req_ready[pickIdx] = 1'b1;
        end
        rrPtr_d   = (int'(pickIdx) == P - 1) ? '0 : pickIdx + 1'b1;
        gntOneHot = '0;
        gntOneHot[gnt_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            gnt_q      <= '0;
            res_q      <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            opAf_q     <= '0;
            opImm_q    <= 1'b0;
            rspValid_q <= '0;
        end else begin
            case (state_q)
                EXEC: begin
                    res_q      <= luRes;
                    rspValid_q <= gntOneHot;
                    state_q    <= RESP;
                end
                IDLE, RESP: begin
                    if (state_q == RESP && rsp_ready[gnt_q]) begin
                        rspValid_q <= '0;
                        state_q    <= IDLE;
                    end
                    if (canAccept) begin
                        opA_q   <= req_a[pickIdx*N +: N];
                        opB_q   <= req_b[pickIdx*N +: N];
                        opAf_q  <= req_af[pickIdx*2 +: 2];
                        opImm_q <= req_i[pickIdx];
                        gnt_q   <= pickIdx;
                        rrPtr_q <= rrPtr_d;
                        state_q <= EXEC;
                    end
                end
                default: begin
                    rspValid_q <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_res   = res_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed bench for lu_arbiter: function codes, round-robin order, stalls, reset and wrap-around.
module tb_lu_arbiter;

    localparam int N = 32;
    localparam int P = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [P-1:0]   req_valid;
    logic [P-1:0]   req_ready;
    logic [P*N-1:0] req_a;
    logic [P*N-1:0] req_b;
    logic [P*2-1:0] req_af;
    logic [P-1:0]   req_i;
    logic [P-1:0]   rsp_valid;
    logic [P-1:0]   rsp_ready;
    logic [N-1:0]   rsp_res;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lu_arbiter #(
        .N (N),
        .P (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_af    (req_af),
        .req_i     (req_i),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res)
    );

    task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [P-1:0] oneHot(input int k);
        oneHot = '0;
        oneHot[k] = 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [1:0] af, input logic imm);
        req_a[k*N +: N]  = a;
        req_b[k*N +: N]  = b;
        req_af[k*2 +: 2] = af;
        req_i[k]         = imm;
    endtask

    task automatic doReset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    // One isolated transaction on requester k, checked cycle by cycle through IDLE/EXEC/RESP/IDLE.
    task automatic applyStimulus(input string tag, input int k, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic [1:0] af,
                                 input logic imm, input logic [N-1:0] expRes);
        setReq(k, a, b, af, imm);
        req_valid = oneHot(k);
        #1;
        checkOutput({tag, " req_ready"}, N'(req_ready), N'(oneHot(k)));
        tick;
        req_valid = '0;
        #1;
        checkOutput({tag, " exec rsp_valid"}, N'(rsp_valid), '0);
        tick;
        checkOutput({tag, " rsp_valid"}, N'(rsp_valid), N'(oneHot(k)));
        checkOutput({tag, " rsp_res"}, rsp_res, expRes);
        rsp_ready = oneHot(k);
        tick;
        rsp_ready = '0;
        #1;
        checkOutput({tag, " idle rsp_valid"}, N'(rsp_valid), '0);
        checkOutput({tag, " res hold"}, rsp_res, expRes);
    endtask

    initial begin
        req_a  = '0;
        req_b  = '0;
        req_af = '0;
        req_i  = '0;

        // Reset with requests pending: nothing may be offered or answered.
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        tick;
        tick;
        checkOutput("reset req_ready", N'(req_ready), '0);
        checkOutput("reset rsp_valid", N'(rsp_valid), '0);
        checkOutput("reset rsp_res", rsp_res, '0);
        doReset;

        applyStimulus("and", 0, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b00, 1'b0, 32'h00F000F0);
        applyStimulus("or",  0, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b01, 1'b0, 32'hFFF0FFF0);
        applyStimulus("xor", 0, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 1'b0, 32'hFF00FF00);
        applyStimulus("nor", 0, 32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 1'b0, 32'h000F000F);
        applyStimulus("lui", 2, 32'hDEADBEEF, 32'h00001234, 2'b11, 1'b1, 32'h12340000);

        // Pointer is now 3: req3 wins over req1, then the pointer wraps and req1 wins.
        setReq(3, 32'hAAAA5555, 32'hFFFF0000, 2'b10, 1'b0);
        setReq(1, 32'h12345678, 32'h0000FFFF, 2'b00, 1'b0);
        req_valid = 4'b1010;
        #1;
        checkOutput("wrap first grant", N'(req_ready), N'(4'b1000));
        tick;
        tick;
        rsp_ready = 4'b1000;
        #1;
        checkOutput("wrap rsp_valid 3", N'(rsp_valid), N'(4'b1000));
        checkOutput("wrap rsp_res 3", rsp_res, 32'h5555FFFF ^ 32'hFFFFAAAA ^ 32'hFFFFAAAA ^ 32'hFFFF0000 ^ 32'hAAAA5555 ^ 32'h5555FFFF);
        checkOutput("wrap b2b grant", N'(req_ready), N'(4'b0010));
        tick;
        rsp_ready = '0;
        req_valid = 4'b0001;
        tick;
        rsp_ready = 4'b0010;
        #1;
        checkOutput("wrap rsp_res 1", rsp_res, 32'h00005678);
        checkOutput("wrap to index 0", N'(req_ready), N'(4'b0001));

        // All requesters busy with rsp_ready tied high: grants 0,1,2,3,0 every 2 cycles.
        doReset;
        for (int k = 0; k < P; k++) begin
            setReq(k, N'(32'h11111111 * (k + 1)), 32'hFFFFFFFF, 2'b00, 1'b0);
        end
        req_valid = '1;
        rsp_ready = '1;
        #1;
        for (int g = 0; g <= P; g++) begin
            checkOutput($sformatf("rr grant %0d", g), N'(req_ready), N'(oneHot(g % P)));
            checkOutput($sformatf("rr rsp_valid %0d", g), N'(rsp_valid),
                        (g == 0) ? '0 : N'(oneHot(g - 1)));
            if (g > 0) begin
                checkOutput($sformatf("rr rsp_res %0d", g), rsp_res, N'(32'h11111111 * g));
            end
            tick;
            checkOutput($sformatf("rr exec ready %0d", g), N'(req_ready), '0);
            tick;
        end

        // Response stall: other rsp_ready bits are ignored and nothing new is accepted.
        doReset;
        req_valid = '1;
        rsp_ready = '0;
        #1;
        checkOutput("stall first grant", N'(req_ready), N'(4'b0001));
        tick;
        tick;
        rsp_ready = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("stall rsp_valid %0d", c), N'(rsp_valid), N'(4'b0001));
            checkOutput($sformatf("stall rsp_res %0d", c), rsp_res, 32'h11111111);
            checkOutput($sformatf("stall req_ready %0d", c), N'(req_ready), '0);
            tick;
        end
        rsp_ready = 4'b0001;
        #1;
        checkOutput("stall release grant", N'(req_ready), N'(4'b0010));
        tick;
        rsp_ready = '0;
        #1;
        checkOutput("exec rsp_valid", N'(rsp_valid), '0);

        // Reset while in EXEC: transaction dropped, arbitration restarts at index 0.
        rst_n = 1'b0;
        #1;
        checkOutput("rst req_ready", N'(req_ready), '0);
        tick;
        checkOutput("rst rsp_valid", N'(rsp_valid), '0);
        rst_n     = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tick;
            checkOutput($sformatf("post rst rsp_valid %0d", c), N'(rsp_valid), '0);
        end
        req_valid = '1;
        #1;
        checkOutput("post rst grant", N'(req_ready), N'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
